// File: rtl/fft_host_pkg.sv
// Shared types and default widths for the FFT streaming host.
package fft_host_pkg;

  localparam int unsigned DEF_IDX_W      = 12;
  localparam int unsigned DEF_BURST_W    = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned SMP_W          = 16;
  localparam int unsigned RES_W          = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One FFT result word as carried on the write channel.
  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and an always-visible head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB separates full from empty after wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; entries are only visible once the write pointer passes them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/fft_stream_host.sv
// Host-side peer of the FFT engine: streams buffered samples out, collects indexed results.
module fft_stream_host
  import fft_host_pkg::*;
#(
  parameter int unsigned BURST_W    = DEF_BURST_W,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic [IDX_W-1:0]     i_samp_number,
  input  logic [SMP_W-1:0]     i_smp_data,
  input  logic                 i_smp_valid,
  output logic                 o_smp_ready,
  output logic [SMP_W-1:0]     o_RDATA,
  output logic                 o_RVALID,
  input  logic                 i_RREADY,
  input  logic [BURST_W-1:0]   i_RBURST,
  input  logic [RES_W-1:0]     i_WDATA,
  input  logic                 i_WVALID,
  output logic                 o_WREADY,
  input  logic [BURST_W-1:0]   i_WBURST,
  output logic [RES_W-1:0]     o_res_data,
  output logic [IDX_W-1:0]     o_res_index,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*BURST_W-1:0] o_burst_status
);

  state_t             state;
  logic [IDX_W-1:0]   n_lat;
  logic [IDX_W-1:0]   sent_cnt;
  logic [IDX_W-1:0]   rcv_cnt;
  logic [IDX_W-1:0]   last_idx;
  result_t            res_q;
  logic [IDX_W-1:0]   res_index;
  logic               res_valid;
  logic [BURST_W-1:0] rburst_q;
  logic [BURST_W-1:0] wburst_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [SMP_W-1:0]   fifo_head;
  logic               push;
  logic               r_valid;
  logic               r_beat;
  logic               w_ready;
  logic               w_beat;

  assign push     = i_smp_valid && !fifo_full;
  assign r_valid  = (state == SEND) && !fifo_empty;
  assign r_beat   = r_valid && i_RREADY;
  assign w_ready  = (state == COLLECT) && (!res_valid || i_res_ready);
  assign w_beat   = i_WVALID && w_ready;
  assign last_idx = n_lat - IDX_W'(1);

  sync_fifo #(
    .WIDTH (SMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .push    (push),
    .data_in (i_smp_data),
    .pop     (r_beat),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Transform sequencing: latch length, count sample and result beats.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      n_lat    <= '0;
      sent_cnt <= '0;
      rcv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            n_lat    <= i_samp_number;
            sent_cnt <= '0;
            rcv_cnt  <= '0;
            state    <= (i_samp_number == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (r_beat) begin
            sent_cnt <= sent_cnt + IDX_W'(1);
            if (sent_cnt == last_idx) state <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_beat) begin
            rcv_cnt <= rcv_cnt + IDX_W'(1);
            if (rcv_cnt == last_idx) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result output register; holds until the consumer takes it or a new beat replaces it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      res_q     <= '0;
      res_index <= '0;
      res_valid <= 1'b0;
    end else if (w_beat) begin
      res_q     <= result_t'(i_WDATA);
      res_index <= rcv_cnt;
      res_valid <= 1'b1;
    end else if (i_res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Capture burst sideband of the most recent accepted beat on each channel.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rburst_q <= '0;
      wburst_q <= '0;
    end else begin
      if (r_beat) rburst_q <= i_RBURST;
      if (w_beat) wburst_q <= i_WBURST;
    end
  end

  assign o_smp_ready    = !fifo_full;
  assign o_RVALID       = r_valid;
  assign o_RDATA        = r_valid ? fifo_head : '0;
  assign o_WREADY       = w_ready;
  assign o_res_data     = res_q;
  assign o_res_index    = res_index;
  assign o_res_valid    = res_valid;
  assign o_busy         = (state != IDLE);
  assign o_done         = (state == DONE);
  assign o_burst_status = {wburst_q, rburst_q};

endmodule
